// File: rtl/alu_seq_pkg.sv
// ============================================================================
// alu_seq_pkg : shared state encoding and opcode constants for alu_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  localparam int         INSTR_LEN = 3;
  localparam logic [7:0] OP_ADD    = 8'h00;
  localparam logic [7:0] OP_MUL    = 8'h01;
  localparam logic [7:0] OP_HALT   = 8'hFF;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    F_OP   = 4'd1,
    W_OP   = 4'd2,
    W_A    = 4'd3,
    W_B    = 4'd4,
    EXEC   = 4'd5,
    MSTEP  = 4'd6,
    NEXT   = 4'd7,
    HALTED = 4'd8
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_step_counter.sv
// ============================================================================
// seq_step_counter : loadable down-counter with zero flag for MUL iterations
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_step_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Saturates at zero so a stray decrement can never wrap into a long loop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// alu_sequencer : microprogram sequencer for ROM -> regA/regB -> ALU -> regC
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_sequencer #(
  parameter int            AW      = 9,
  parameter int            DW      = 8,
  parameter logic [DW-1:0] OP_ADD  = alu_seq_pkg::OP_ADD,
  parameter logic [DW-1:0] OP_MUL  = alu_seq_pkg::OP_MUL,
  parameter logic [DW-1:0] OP_HALT = alu_seq_pkg::OP_HALT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          en_a,
  output logic          en_b,
  output logic          en_c,
  output logic          acc_clr,
  output logic          mux_sel,
  output logic          busy,
  output logic          done,
  output logic          res_valid,
  output logic          err_illegal,
  output logic          err_range
);

  import alu_seq_pkg::*;

  // Last pc whose successor triple still fits entirely inside the ROM.
  localparam logic [AW:0] C_PC_LIMIT = (AW+1)'((2**AW) - INSTR_LEN);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_nxt;
  logic [DW-1:0] r_opcode;
  logic [DW-1:0] w_opcode_nxt;
  logic          r_err_illegal;
  logic          w_err_illegal_nxt;
  logic          r_err_range;
  logic          w_err_range_nxt;
  logic          w_cnt_load;
  logic          w_cnt_dec;
  logic          w_cnt_zero;
  logic [AW:0]   w_pc_plus3;

  assign w_pc_plus3 = {1'b0, r_pc} + (AW+1)'(INSTR_LEN);

  seq_step_counter #(
    .W (DW)
  ) u_step_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (rom_data),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pc          <= '0;
      r_opcode      <= '0;
      r_err_illegal <= 1'b0;
      r_err_range   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_opcode      <= w_opcode_nxt;
      r_err_illegal <= w_err_illegal_nxt;
      r_err_range   <= w_err_range_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_opcode_nxt      = r_opcode;
    w_err_illegal_nxt = r_err_illegal;
    w_err_range_nxt   = r_err_range;
    w_cnt_load        = 1'b0;
    w_cnt_dec         = 1'b0;
    case (r_state)
      IDLE, HALTED: begin
        if (start) begin
          w_state_nxt       = F_OP;
          w_pc_nxt          = '0;
          w_err_illegal_nxt = 1'b0;
          w_err_range_nxt   = 1'b0;
        end
      end
      F_OP: w_state_nxt = W_OP;
      W_OP: begin
        w_opcode_nxt = rom_data;
        if (rom_data == OP_HALT) begin
          w_state_nxt = HALTED;
        end else if ((rom_data == OP_ADD) || (rom_data == OP_MUL)) begin
          w_state_nxt = W_A;
        end else begin
          // Unknown opcode: skip the whole triple without touching the datapath.
          w_err_illegal_nxt = 1'b1;
          w_pc_nxt          = w_pc_plus3[AW-1:0];
          w_state_nxt       = F_OP;
        end
      end
      W_A: w_state_nxt = W_B;
      W_B: begin
        w_cnt_load  = 1'b1;
        w_state_nxt = (r_opcode == OP_MUL) ? MSTEP : EXEC;
      end
      EXEC: w_state_nxt = NEXT;
      MSTEP: begin
        if (w_cnt_zero) begin
          w_state_nxt = NEXT;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      NEXT: begin
        if (w_pc_plus3 > C_PC_LIMIT) begin
          w_err_range_nxt = 1'b1;
          w_state_nxt     = HALTED;
        end else begin
          w_pc_nxt    = w_pc_plus3[AW-1:0];
          w_state_nxt = F_OP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs depend only on registered state so they are stable for the whole cycle.
  always_comb begin
    rom_addr  = r_pc;
    en_a      = 1'b0;
    en_b      = 1'b0;
    en_c      = 1'b0;
    acc_clr   = 1'b0;
    mux_sel   = 1'b0;
    res_valid = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    case (r_state)
      IDLE:   busy = 1'b0;
      F_OP:   rom_addr = r_pc;
      W_OP:   rom_addr = r_pc + AW'(1);
      W_A: begin
        en_a     = 1'b1;
        rom_addr = r_pc + AW'(2);
      end
      W_B: begin
        en_b    = 1'b1;
        acc_clr = (r_opcode == OP_MUL);
      end
      EXEC:   en_c = 1'b1;
      MSTEP: begin
        mux_sel = 1'b1;
        en_c    = !w_cnt_zero;
      end
      NEXT:   res_valid = 1'b1;
      HALTED: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign err_illegal = r_err_illegal;
  assign err_range   = r_err_range;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// tb_alu_sequencer : directed scoreboard bench with ROM and datapath model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

  localparam int AW = 9;
  localparam int DW = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data = '0;
  logic          en_a, en_b, en_c, acc_clr, mux_sel;
  logic          busy, done, res_valid, err_illegal, err_range;

  always #5 clk = ~clk;

  alu_sequencer #(.AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .en_a        (en_a),
    .en_b        (en_b),
    .en_c        (en_c),
    .acc_clr     (acc_clr),
    .mux_sel     (mux_sel),
    .busy        (busy),
    .done        (done),
    .res_valid   (res_valid),
    .err_illegal (err_illegal),
    .err_range   (err_range)
  );

  // Environment: synchronous ROM plus regA/regB/regC datapath.
  logic [7:0]  rom [512];
  logic [7:0]  reg_a = '0;
  logic [7:0]  reg_b = '0;
  logic [15:0] reg_c = '0;

  always @(posedge clk) begin
    rom_data <= rom[rom_addr];
    if (en_a) reg_a <= rom_data;
    if (en_b) reg_b <= rom_data;
    if (acc_clr)   reg_c <= '0;
    else if (en_c) reg_c <= mux_sel ? ({8'h00, reg_a} + reg_c) : ({8'h00, reg_a} + {8'h00, reg_b});
  end

  int n_en_a = 0, n_en_b = 0, n_en_c = 0, n_acc_clr = 0, n_res = 0;
  always @(negedge clk) begin
    if (en_a)      n_en_a++;
    if (en_b)      n_en_b++;
    if (en_c)      n_en_c++;
    if (acc_clr)   n_acc_clr++;
    if (res_valid) n_res++;
  end

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;

  always @(negedge clk) begin
    if (res_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL res_unexpected: got regC=%0d, required no result pending", reg_c);
      end else begin
        mon_exp = exp_q.pop_front();
        if (reg_c !== mon_exp) begin
          n_fail++;
          $display("FAIL res_regC: got %0d, required %0d", reg_c, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 512; i++) rom[i] = v;
  endtask

  // Pulses start, then counts edges until done; optionally re-pulses start mid-run.
  task automatic run_prog(input int poke, output int cycles);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cycles = 0;
    while (cycles < 5000) begin
      @(posedge clk);
      #1;
      cycles++;
      start = (poke != 0 && cycles == poke);
      if (poke != 0 && cycles == poke + 2) chk("busy_after_start", 32'(busy), 1);
      if (done) break;
    end
    start = 1'b0;
  endtask

  int cyc, s_res, s_a, s_b, s_c, s_clr, k;

  initial begin
    fill_rom(8'hFF);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", 32'({en_a, en_b, en_c, acc_clr, mux_sel, busy, done, res_valid, err_illegal, err_range}), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    @(negedge clk) rst_n = 1'b1;

    // ADD 5+3
    rom[0] = 8'h00; rom[1] = 8'h05; rom[2] = 8'h03; rom[3] = 8'hFF;
    s_res = n_res;
    exp_q.push_back(16'd8);
    run_prog(0, cyc);
    chk("t1_cycles", cyc, 8);
    chk("t1_regc", 32'(reg_c), 8);
    chk("t1_res_pulses", n_res - s_res, 1);
    chk("t1_errs", 32'({err_illegal, err_range}), 0);

    // Illegal opcode skipped, then ADD 1+1
    fill_rom(8'hFF);
    rom[0] = 8'h7A; rom[3] = 8'h00; rom[4] = 8'h01; rom[5] = 8'h01; rom[6] = 8'hFF;
    s_a = n_en_a; s_b = n_en_b; s_c = n_en_c;
    exp_q.push_back(16'd2);
    run_prog(0, cyc);
    chk("t4_cycles", cyc, 10);
    chk("t4_err_illegal", 32'(err_illegal), 1);
    chk("t4_en_a_pulses", n_en_a - s_a, 1);
    chk("t4_en_b_pulses", n_en_b - s_b, 1);
    chk("t4_en_c_pulses", n_en_c - s_c, 1);
    chk("t4_regc", 32'(reg_c), 2);
    chk("t4_done", 32'(done), 1);

    // MUL 4*3
    fill_rom(8'hFF);
    rom[0] = 8'h01; rom[1] = 8'h04; rom[2] = 8'h03; rom[3] = 8'hFF;
    s_c = n_en_c;
    exp_q.push_back(16'd12);
    run_prog(0, cyc);
    chk("t2_cycles", cyc, 11);
    chk("t2_en_c_pulses", n_en_c - s_c, 3);
    chk("t2_regc", 32'(reg_c), 12);
    chk("t2_err_illegal_cleared", 32'(err_illegal), 0);

    // MUL 9*0
    rom[0] = 8'h01; rom[1] = 8'h09; rom[2] = 8'h00; rom[3] = 8'hFF;
    s_c = n_en_c; s_clr = n_acc_clr;
    exp_q.push_back(16'd0);
    run_prog(0, cyc);
    chk("t3_cycles", cyc, 8);
    chk("t3_acc_clr_pulses", n_acc_clr - s_clr, 1);
    chk("t3_en_c_pulses", n_en_c - s_c, 0);
    chk("t3_regc", 32'(reg_c), 0);

    // Reset in the second MSTEP cycle of MUL 4*3, then rerun
    rom[0] = 8'h01; rom[1] = 8'h04; rom[2] = 8'h03; rom[3] = 8'hFF;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    s_c = n_en_c;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!mux_sel && k < 50);
    @(negedge clk);
    chk("t5_in_mstep", 32'(mux_sel), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_en_c_before_rst", n_en_c - s_c, 2);
    chk("t5_rst_outputs", 32'({en_a, en_b, en_c, acc_clr, mux_sel, busy, done, res_valid, err_illegal, err_range}), 0);
    chk("t5_rst_rom_addr", 32'(rom_addr), 0);
    s_c = n_en_c;
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_no_en_c_after_rst", n_en_c - s_c, 0);
    exp_q.push_back(16'd12);
    run_prog(0, cyc);
    chk("t5_rerun_cycles", cyc, 11);
    chk("t5_rerun_regc", 32'(reg_c), 12);

    // No HALT: run off the end of the ROM, with a start poke while busy
    for (int i = 0; i < 512; i++) rom[i] = (i >= 510) ? 8'h00 : ((i % 3 == 0) ? 8'h00 : 8'h01);
    s_res = n_res;
    for (int i = 0; i < 170; i++) exp_q.push_back(16'd2);
    run_prog(100, cyc);
    chk("t6_cycles", cyc, 1020);
    chk("t6_res_pulses", n_res - s_res, 170);
    chk("t6_err_range", 32'(err_range), 1);
    chk("t6_done", 32'(done), 1);
    chk("t6_regc", 32'(reg_c), 2);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Microprogram sequencer for the ROM → regA/regB → ALU → regC datapath. It fetches 3-byte instructions (opcode, operand A, operand B) from the program ROM and drives the register enables. It runs ADD in one ALU pass and MUL as repeated addition through the regC feedback mux path. It reports busy, done and error status to the top level.

Parameters:
AW, 9, ROM address width (matches the 9-bit program ROM)
DW, 8, ROM data / operand width
OP_ADD, 8'h00, opcode for ADD
OP_MUL, 8'h01, opcode for MUL
OP_HALT, 8'hFF, opcode that ends the program

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-low
start  in  1  begin program at address 0; sampled only in IDLE or HALTED
rom_addr  out  AW  ROM address; ROM returns data one cycle later
rom_data  in  DW  ROM read data
en_a  out  1  load regA from rom_data
en_b  out  1  load regB from rom_data
en_c  out  1  load regC from the result mux
acc_clr  out  1  clear regC to 0
mux_sel  out  1  0: ALU = A + B; 1: ALU = A + regC (feedback)
busy  out  1  high in every state except IDLE and HALTED
done  out  1  high while in HALTED
res_valid  out  1  one-cycle pulse in NEXT, after each completed instruction
err_illegal  out  1  sticky: an unknown opcode was skipped
err_range  out  1  sticky: pc ran past the end of the ROM without a HALT

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, pc=0, cnt=0.
  - All outputs 0, rom_addr=0.
  - Reset overrides everything, including a reset mid-MUL. No partial regC write occurs after the reset edge.
- Internal registers: pc[AW-1:0], opcode[DW-1:0], cnt[DW-1:0].
- Registered Moore outputs. The strobes en_a, en_b, en_c, acc_clr, res_valid are asserted only in the state listed below.
- States and transitions:
  - IDLE: start=1 → pc=0, clear err_* → F_OP.
  - F_OP: rom_addr=pc → W_OP.
  - W_OP: latch opcode=rom_data; rom_addr=pc+1.
    - OP_HALT → HALTED.
    - OP_ADD or OP_MUL → W_A.
    - Any other value → set err_illegal, pc=pc+3 → F_OP. No strobes are asserted.
  - W_A: en_a=1; rom_addr=pc+2 → W_B.
  - W_B: en_b=1; cnt=rom_data.
    - ADD → EXEC.
    - MUL → acc_clr=1 in this same cycle → MSTEP.
  - EXEC: mux_sel=0, en_c=1 → NEXT.
  - MSTEP: mux_sel=1.
    - cnt≠0 → en_c=1, cnt=cnt-1, stay in MSTEP.
    - cnt=0 → NEXT, no en_c.
  - NEXT: res_valid=1.
    - pc+3 > 2^AW-3 → set err_range → HALTED.
    - Otherwise pc=pc+3 → F_OP.
  - HALTED: done=1; start=1 → same action as IDLE.
- Latency:
  - ADD takes 6 cycles from F_OP to the end of NEXT.
  - MUL takes B+6 cycles; B=0 gives 6 cycles and regC=0.
  - An illegal opcode costs 2 cycles.
- Result width: A and B are 8-bit unsigned, so the regC product is at most 255·255=65025 and fits in 16 bits. No overflow handling is needed.
- start while busy=1 is ignored.
- start held high across HALTED restarts the program every time HALTED is reached. This is legal.

Decomposition:
- Shared package alu_seq_pkg holds:
  - state enum (IDLE, F_OP, W_OP, W_A, W_B, EXEC, MSTEP, NEXT, HALTED)
  - opcode constants OP_ADD, OP_MUL, OP_HALT
  - INSTR_LEN=3
- Optional sub-module seq_step_counter: 8-bit loadable down-counter with a zero flag, used by MSTEP.
- Everything else stays in a single FSM module.

Test Plan:
1. ROM[0..2]=00,05,03 and ROM[3]=FF; start pulse.
   → regC=8, one res_valid pulse, done=1 at cycle 8 after start, no errors.
2. ROM[0..2]=01,04,03 and ROM[3]=FF.
   → exactly 3 en_c pulses, regC=12, MUL takes 9 cycles, then done.
3. ROM[0..2]=01,09,00 and ROM[3]=FF.
   → acc_clr pulse, zero en_c pulses, regC=0, MUL takes 6 cycles.
4. ROM[0]=7A, ROM[3..5]=00,01,01, ROM[6]=FF.
   → err_illegal=1, no strobes for address 0, regC=2, done=1.
5. Program as in test 2 with rst_n=0 for 1 cycle during the second MSTEP cycle.
   → next cycle state=IDLE, all outputs 0, no further en_c; a later start reruns the program to regC=12.
6. ROM filled with 00,01,01 triples and no HALT.
   → after the triple at 507, err_range=1 and done=1; start while busy is ignored (checked mid-run).
